dds_cmd_loader: RTL
===================

# dds_cmd_loader

Byte-stream command parser that sits directly upstream of the DDS core and drives all of its control inputs. It accepts framed commands over a valid/ready byte interface, fills the waveform RAM through the write port, and updates frequency and phase with single-cycle strobes. It replaces bench-driven pin wiggling with a host/UART-facing front end.

## Interface
- DATA_W, 8, width of one waveform sample and `data_wr`; equals `DATA_LEN`.
- ADDR_W, 8, waveform RAM address width, 1..8; equals `ROWS_BASE_2`.
- TIMEOUT_CYC, 1000, idle cycles mid-packet before abort; used only with the timeout macro.
- src_clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  command/payload byte.
- in_valid  in  1  `in_data` valid.
- in_ready  out  1  byte accepted on an edge where `in_valid & in_ready`.
- data_wr  out  DATA_W  sample to DDS RAM.
- addr_wr  out  ADDR_W  RAM write address.
- we  out  1  RAM write strobe, one cycle per sample.
- freq  out  32  DDS tuning word, held between commands.
- set_freq  out  1  one-cycle strobe when `freq` is updated.
- phase  out  9  DDS phase offset, held between commands.
- set_phase  out  1  one-cycle strobe when `phase` is updated.
- busy  out  1  high whenever the state is not IDLE.
- err  out  1  one-cycle pulse on a bad opcode or timeout.
- err_cnt  out  8  saturating error count (stops at 255).

## Operation
- Packets: first byte is the opcode.
  - 0x01 LOAD: ADDR, CNT, then CNT samples. CNT=0 means 256.
  - 0x02 FREQ: 4 bytes, MSB first.
  - 0x03 PHASE: 2 bytes. `phase = {b0[0], b1}`; b0[7:1] are ignored.
- States: IDLE, L_ADDR, L_CNT, L_DATA, F_BYTE, P_BYTE.
  - IDLE: 0x01 goes to L_ADDR, 0x02 to F_BYTE, 0x03 to P_BYTE.
  - Any other opcode in IDLE: `err` pulses, `err_cnt` increments, the state stays IDLE and the byte is dropped.
- L_ADDR: latches `ptr = ADDR[ADDR_W-1:0]`; upper bits are ignored.
- L_CNT: latches the remaining count (9-bit, 0 becomes 256).
- L_DATA: for each accepted byte, `data_wr = byte[DATA_W-1:0]`, `addr_wr = ptr`, `we = 1`.
  - After each write, `ptr` increments mod 2^ADDR_W (it wraps 255→0) and the remaining count decrements.
  - The state returns to IDLE after the last sample.
- F_BYTE: shifts the 4 bytes into a shadow register.
  - On the 4th byte, `freq` is loaded from the shadow register and `set_freq` pulses.
  - `freq` never changes to a partial value.
- P_BYTE: same scheme with 2 bytes, loading `phase` and pulsing `set_phase`.
- `in_ready`:
  - 0 while `rst` is high.
  - 1 from the first cycle after reset deasserts, in every state.
  - The block never stalls, so back-to-back bytes give back-to-back `we` cycles.
- Reset mid-packet (any state):
  - The packet is discarded and the state goes to IDLE.
  - No strobe is issued.
  - `freq` and `phase` return to 0.
  - `err_cnt` clears.
- `in_valid` low simply holds the state. There is no implicit abort without the timeout macro.

## Timing
- Reset values:
  - `in_ready`, `we`, `set_freq`, `set_phase`, `busy`, `err` = 0.
  - `data_wr`, `addr_wr`, `freq`, `phase`, `err_cnt` = 0.
- All outputs are registered.
- A byte accepted at edge k produces its effect (`we`, `set_*`, `err`, `busy` change) during cycle k+1, i.e. after edge k.
- Strobes are exactly one cycle wide.
- `data_wr` and `addr_wr` hold their last values when `we` = 0.
- `busy` rises in the cycle after the opcode is accepted. It falls in the same cycle as the final `we` or `set_*` strobe.
- An opcode may be accepted on the edge right after a packet's last byte, with no gap cycle.

## Configuration
- `DDS_LOADER_TIMEOUT_EN` defined:
  - A cycle counter runs while the state is not IDLE.
  - It resets on every accepted byte.
  - When it reaches TIMEOUT_CYC consecutive cycles with no accepted byte:
    - the state goes to IDLE and `err` pulses;
    - `err_cnt` increments;
    - `freq`, `phase` and RAM contents already written are unchanged.
- Not defined: no counter is built, and a partial packet waits indefinitely.

## Test plan
- Reset, then LOAD `01 FE 04 0A 0B 0C 0D`, sent back-to-back → 4 consecutive `we` cycles with (addr, data) = (FE,0A), (FF,0B), (00,0C), (01,0D); `busy` falls with the last `we`.
- FREQ `02 00 00 01 F4` → `freq` = 500 with one `set_freq` cycle; no `freq` change during bytes 1-3. Then FREQ 6400 → `freq` = 0x1900.
- PHASE `03 00 2D` → `phase` = 45 with one `set_phase` pulse. PHASE `03 FF 00` → `phase` = 256.
- Opcode `7E` → `err` pulse, `err_cnt` = 1, state stays IDLE. A following FREQ packet is accepted normally.
- `rst` asserted after `02 12 34` → `busy` = 0, `freq` = 0, no `set_freq`. A subsequent full FREQ packet works.
- With `DDS_LOADER_TIMEOUT_EN` and TIMEOUT_CYC = 8: `01 10` then `in_valid` = 0 for 8 cycles → `err` pulse, IDLE, no `we`. Without the macro: still `busy` after 100 cycles.

Source files
------------

// File: rtl/dds_cmd_loader.sv
// Byte-stream command front end for the DDS core: LOAD fills waveform RAM, FREQ/PHASE update tuning.
// Optional mid-packet timeout abort is built only when DDS_LOADER_TIMEOUT_EN is defined.
module dds_cmd_loader #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              src_clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_wr,
  output logic [ADDR_W-1:0] addr_wr,
  output logic              we,
  output logic [31:0]       freq,
  output logic              set_freq,
  output logic [8:0]        phase,
  output logic              set_phase,
  output logic              busy,
  output logic              err,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_L_ADDR, S_L_CNT, S_L_DATA, S_F_BYTE, S_P_BYTE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [1:0]        idx_q, idx_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       freq_q, freq_d;
  logic              set_freq_q, set_freq_d;
  logic [8:0]        phase_q, phase_d;
  logic              set_phase_q, set_phase_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              accept;
  logic              timeout;

  assign accept = in_valid & in_ready_q;

`ifdef DDS_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts consecutive stalled cycles inside a packet; fires on the TIMEOUT_CYC-th one.
  always_comb begin
    to_cnt_d = to_cnt_q;
    timeout  = 1'b0;
    if (accept || state_q == S_IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
      timeout  = 1'b1;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // State register and all registered outputs.
  always_ff @(posedge src_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: every register here is plain flops (no RAM), so all of them get a reset value.
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      freq_q      <= '0;
      set_freq_q  <= 1'b0;
      phase_q     <= '0;
      set_phase_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      in_ready_q  <= 1'b1;
      data_q      <= data_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      freq_q      <= freq_d;
      set_freq_q  <= set_freq_d;
      phase_q     <= phase_d;
      set_phase_q <= set_phase_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: default every comb output first so no path leaves a latch behind.
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    data_d      = data_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    freq_d      = freq_q;
    set_freq_d  = 1'b0;
    phase_d     = phase_q;
    set_phase_d = 1'b0;
    err_d       = 1'b0;

    if (timeout) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end else if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          idx_d = '0;
          case (in_data)
            8'h01:   state_d = S_L_ADDR;
            8'h02:   state_d = S_F_BYTE;
            8'h03:   state_d = S_P_BYTE;
            default: err_d   = 1'b1;
          endcase
        end
        S_L_ADDR: begin
          ptr_d   = in_data[ADDR_W-1:0];
          state_d = S_L_CNT;
        end
        S_L_CNT: begin
          cnt_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          state_d = S_L_DATA;
        end
        S_L_DATA: begin
          we_d   = 1'b1;
          data_d = in_data[DATA_W-1:0];
          addr_d = ptr_q;
          ptr_d  = ptr_q + 1'b1;
          cnt_d  = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = S_IDLE;
        end
        S_F_BYTE: begin
          shadow_d = {shadow_q[23:0], in_data};
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            freq_d     = {shadow_q[23:0], in_data};
            set_freq_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
        S_P_BYTE: begin
          shadow_d = {shadow_q[23:0], in_data};
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'd1) begin
            phase_d     = {shadow_q[0], in_data};
            set_phase_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  // Output logic.
  always_comb begin
    busy      = (state_q != S_IDLE);
    in_ready  = in_ready_q;
    data_wr   = data_q;
    addr_wr   = addr_q;
    we        = we_q;
    freq      = freq_q;
    set_freq  = set_freq_q;
    phase     = phase_q;
    set_phase = set_phase_q;
    err       = err_q;
    err_cnt   = err_cnt_q;
  end

endmodule
